// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-port front end for a single shared combinational ALU.
// A request is granted in IDLE, its operands are registered onto the ALU inputs,
// the ALU result and flags are captured one cycle later, and the response is
// held on the response channel until the consumer takes it.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  // Port 0: core execute stage
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  // Port 1: branch/address unit
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  // Shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  // Response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_q;      // port granted most recently
  logic             id_q;        // port owning the in-flight operation
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_ctrl_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;

  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             op_illegal;

  // Grant decision: only in IDLE, only to a valid port, never to both.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && req1_valid) begin
        // Round-robin hands the tie to port 1 only when port 0 won last time.
        if (RR_EN && !last_q) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Operand mux for the winning port.
  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    if (gnt1) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end
  end

  // Flag op codes the ALU does not implement; they still go to the ALU.
  always_comb begin
    op_illegal = 1'b1;
    case (alu_ctrl_q)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_illegal = 1'b0;
      default:                                op_illegal = 1'b1;
    endcase
  end

  // Control FSM with registered ALU inputs and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            alu_a_q    <= sel_a;
            alu_b_q    <= sel_b;
            alu_ctrl_q <= sel_op;
            id_q       <= gnt1;
            last_q     <= gnt1;
            state_q    <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= {alu_n, alu_z, alu_c, alu_v};
          rsp_err_q    <= op_illegal;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

  // Invariants of the handshake protocol.
  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_no_ready_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StIdle) |-> !(req0_ready || req1_ready));
  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_flags)
                                   && $stable(rsp_id) && $stable(rsp_err)));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand sequences for
// arbitration order and reset-in-flight, and a randomized run against a
// cycle-level behavioural model of the request/response protocol.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_ready;

  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  logic        f_req0_ready, f_req1_ready;
  logic [31:0] f_alu_a, f_alu_b, f_alu_result;
  logic [2:0]  f_alu_ctrl;
  logic        f_alu_n, f_alu_z, f_alu_c, f_alu_v;
  logic        f_rsp_valid, f_rsp_id, f_rsp_err;
  logic [31:0] f_rsp_result;
  logic [3:0]  f_rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {result, N, Z, C, V}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] bb, r;
    logic        v, c;
    bb = op[0] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, op[0]};
    v  = ~(op[0] ^ a[31] ^ b[31]) & (a[31] ^ s[31]) & ~op[1];
    c  = ~op[1] & s[32];
    case (op)
      3'b000, 3'b001: r = s[31:0];
      3'b010:         r = a & b;
      3'b011:         r = a | b;
      3'b101:         r = {31'd0, s[31] ^ v};
      default:        r = 32'd0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  always_comb {alu_result, alu_n, alu_z, alu_c, alu_v} = alu_fn(alu_a, alu_b, alu_ctrl);
  always_comb {f_alu_result, f_alu_n, f_alu_z, f_alu_c, f_alu_v} =
      alu_fn(f_alu_a, f_alu_b, f_alu_ctrl);

  alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctrl(f_alu_ctrl), .alu_result(f_alu_result),
    .alu_n(f_alu_n), .alu_z(f_alu_z), .alu_c(f_alu_c), .alu_v(f_alu_v),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
    .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags), .rsp_err(f_rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          stall;
    logic [31:0] res;
    logic [3:0]  flags;
    bit          err;
  } vec_t;

  // One isolated request; expected values come from the vector record.
  task automatic run_vec(input vec_t v);
    logic [40:0] exp_rsp;
    exp_rsp = {1'b1, v.port, v.res, v.flags, v.err, 2'b00};
    if (v.port == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    check({v.name, ":grant"}, {req1_ready, req0_ready}, v.port ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check({v.name, ":exec"}, {rsp_valid, req0_ready, req1_ready, alu_a, alu_b, alu_ctrl},
          {3'b000, v.a, v.b, v.op});
    @(posedge clk); #1;
    for (int s = 0; s < v.stall; s++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check({v.name, ":stall"}, {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
                                 req0_ready, req1_ready}, exp_rsp);
      check({v.name, ":alu_hold"}, {alu_a, alu_ctrl}, {v.a, v.op});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check({v.name, ":rsp"}, {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
                             req0_ready, req1_ready}, exp_rsp);
    @(posedge clk); #1;
    @(negedge clk);
    check({v.name, ":rsp_drop"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 7));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[8];
  int   ids_m[$];
  int   ids_f[$];

  // Behavioural model state for the randomized run
  bit          m_last, m_busy, m_rv, hs, p0, p1;
  int          m_exec, win;
  logic [35:0] e_alu;
  logic [31:0] e_res;
  logic [3:0]  e_fl;
  bit          e_err, e_id;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{"add",   1'b0, 32'd5,        32'd7,        3'b000, 0, 32'd12,       4'b0000, 1'b0};
    vecs[1] = '{"sub",   1'b1, 32'd3,        32'd3,        3'b001, 0, 32'd0,        4'b0110, 1'b0};
    vecs[2] = '{"slt",   1'b0, 32'hFFFFFFFF, 32'd1,        3'b101, 3, 32'd1,        4'b0010, 1'b0};
    vecs[3] = '{"ill7",  1'b1, 32'hA,        32'h5,        3'b111, 0, 32'd0,        4'b0100, 1'b1};
    vecs[4] = '{"and",   1'b0, 32'hF0F0,     32'hFF00,     3'b010, 1, 32'hF000,     4'b0000, 1'b0};
    vecs[5] = '{"or",    1'b1, 32'h80000000, 32'd1,        3'b011, 0, 32'h80000001, 4'b1000, 1'b0};
    vecs[6] = '{"addov", 1'b0, 32'h7FFFFFFF, 32'd1,        3'b000, 0, 32'h80000000, 4'b1001, 1'b0};
    vecs[7] = '{"ill4",  1'b0, 32'd1,        32'd2,        3'b100, 2, 32'd0,        4'b0100, 1'b1};

    do_reset();
    @(negedge clk);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}, '0);
    check("reset_alu", {alu_a, alu_b, alu_ctrl, req0_ready, req1_ready}, '0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both ports saturating: round-robin alternates, fixed priority starves port 1.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b000;
    for (int c = 0; c < 40 && (ids_m.size() < 4 || ids_f.size() < 4); c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && ids_m.size() < 4) ids_m.push_back(int'(rsp_id));
      if (f_rsp_valid && rsp_ready && ids_f.size() < 4) ids_f.push_back(int'(f_rsp_id));
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", ids_m.size(), 4);
    check("fp_count", ids_f.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_id%0d", i), (i < ids_m.size()) ? ids_m[i] : -1, i % 2);
      check($sformatf("fp_id%0d", i), (i < ids_f.size()) ? ids_f[i] : -1, 0);
    end

    // Reset while a port-0 request is in EXEC: no response, pointer restored.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000;
    @(negedge clk);
    check("rst_exec:grant", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec:in_reset", {rsp_valid, alu_a, alu_ctrl}, '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_exec:no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = 3'b000;
    @(negedge clk);
    check("rst_exec:first_grant", {rsp_valid, req1_ready, req0_ready}, 3'b001);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("rst_exec:still_no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_exec:new_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd8});
    @(posedge clk); #1;

    // Randomized run against the behavioural model.
    do_reset();
    m_last = 1'b1; m_busy = 1'b0; m_rv = 1'b0; m_exec = 0; p0 = 1'b0; p1 = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      win = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) win = m_last ? 0 : 1;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
      end
      check("rnd:ready", {req1_ready, req0_ready}, {win == 1, win == 0});
      check("rnd:rsp_valid", rsp_valid, m_rv);
      if (m_rv) check("rnd:rsp", {rsp_id, rsp_result, rsp_flags, rsp_err},
                      {e_id, e_res, e_fl, e_err});
      hs = m_rv && rsp_ready;
      @(posedge clk); #1;
      if (win >= 0) begin
        m_busy = 1'b1; m_last = (win == 1); m_exec = 1; e_id = (win == 1);
        if (win == 0) begin
          e_alu = alu_fn(req0_a, req0_b, req0_op); e_err = !(req0_op inside {0, 1, 2, 3, 5});
          p0 = 1'b0;
        end else begin
          e_alu = alu_fn(req1_a, req1_b, req1_op); e_err = !(req1_op inside {0, 1, 2, 3, 5});
          p1 = 1'b0;
        end
        e_res = e_alu[35:4]; e_fl = e_alu[3:0];
      end else if (m_busy) begin
        if (m_rv) begin
          if (hs) begin m_rv = 1'b0; m_busy = 1'b0; end
        end else begin
          m_exec--;
          if (m_exec == 0) m_rv = 1'b1;
        end
      end
      if (p0 && $urandom_range(0, 15) == 0) p0 = 1'b0;
      if (p1 && $urandom_range(0, 15) == 0) p1 = 1'b0;
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; req0_a = rand_val(); req0_b = rand_val(); req0_op = 3'($urandom_range(0, 7));
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; req1_a = rand_val(); req1_b = rand_val(); req1_op = 3'($urandom_range(0, 7));
      end
      req0_valid = p0;
      req1_valid = p1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
